// File: rtl/sort_pkg.sv
// Shared types and constants for the quicksort front end (loader and sorter).
package sort_pkg;

  localparam int ELEM_W = 4;
  localparam int IDX_W  = 4;

  localparam logic [ELEM_W-1:0] PAD_VALUE = 4'hF;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } loader_state_e;

endpackage

// File: rtl/sort_loader.sv
// Packs a serial element stream into a frame, kicks the sorter and stalls until it finishes.
// Optional SORT_LOADER_PARTIAL_EN: in_last closes a frame early and pads unwritten slots.
module sort_loader
  import sort_pkg::*;
#(
  parameter int ARR_WIDTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [ELEM_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [ARR_WIDTH*ELEM_W-1:0] sort_array,
  output logic                        sort_enable,
  output logic [IDX_W-1:0]            sort_lo_ind,
  output logic [IDX_W-1:0]            sort_hi_ind,
  input  logic                        sort_done,
  output logic                        busy,
  output logic [7:0]                  frame_count
);

  localparam int ARR_BITS = ARR_WIDTH * ELEM_W;
  localparam int SEL_W    = $clog2(ARR_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_WIDTH - 1);

  loader_state_e         state_q, state_d;
  logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ARR_BITS-1:0]   arr_q, arr_d;
  logic [IDX_W-1:0]      hi_q, hi_d;
  logic                  in_ready_q, in_ready_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;
  logic [7:0]            count_q, count_d;

  logic                  accept_s;
  logic                  close_s;
  logic [SEL_W-1:0]      wr_base_s;

  assign accept_s  = in_valid & in_ready_q & (state_q == FILL);
  assign wr_base_s = SEL_W'({wr_ptr_q, 2'b00});

`ifdef SORT_LOADER_PARTIAL_EN
  assign close_s = accept_s & ((wr_ptr_q == LAST_IDX) | in_last);
`else
  logic unused_last_s;
  assign unused_last_s = in_last;
  assign close_s       = accept_s & (wr_ptr_q == LAST_IDX);
`endif

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      wr_ptr_q   <= 4'd0;
      arr_q      <= '0;
      hi_q       <= 4'd0;
      in_ready_q <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      arr_q      <= arr_d;
      hi_q       <= hi_d;
      in_ready_q <= in_ready_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    arr_d      = arr_q;
    hi_d       = hi_q;
    in_ready_d = in_ready_q;
    enable_d   = 1'b0;
    busy_d     = busy_q;
    count_d    = count_q;
    case (state_q)
      FILL: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (accept_s) begin
          arr_d[wr_base_s +: ELEM_W] = in_data;
          wr_ptr_d                   = wr_ptr_q + 4'd1;
          if (close_s) begin
`ifdef SORT_LOADER_PARTIAL_EN
            // Slots past the closing element get the pad so the sorter sees no stale data
            for (int i = 0; i < ARR_WIDTH; i++) begin
              if (IDX_W'(i) > wr_ptr_q) begin
                arr_d[SEL_W'(i * ELEM_W) +: ELEM_W] = PAD_VALUE;
              end else begin
                arr_d[SEL_W'(i * ELEM_W) +: ELEM_W] = arr_d[SEL_W'(i * ELEM_W) +: ELEM_W];
              end
            end
`endif
            hi_d       = wr_ptr_q;
            in_ready_d = 1'b0;
            enable_d   = 1'b1;
            busy_d     = 1'b1;
            state_d    = ISSUE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (sort_done) begin
          count_d    = count_q + 8'd1;
          wr_ptr_d   = 4'd0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = FILL;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d    = FILL;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign in_ready    = in_ready_q;
  assign sort_array  = arr_q;
  assign sort_enable = enable_q;
  assign sort_lo_ind = 4'd0;
  assign sort_hi_ind = hi_q;
  assign busy        = busy_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_sort_loader.sv
// Directed, table-driven bench for sort_loader (ARR_WIDTH=4); partial-frame cases
// are enabled when SORT_LOADER_PARTIAL_EN is defined.
module tb_sort_loader;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [15:0] sort_array;
  logic        sort_enable;
  logic [3:0]  sort_lo_ind;
  logic [3:0]  sort_hi_ind;
  logic        sort_done;
  logic        busy;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  sort_loader #(.ARR_WIDTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .sort_array  (sort_array),
    .sort_enable (sort_enable),
    .sort_lo_ind (sort_lo_ind),
    .sort_hi_ind (sort_hi_ind),
    .sort_done   (sort_done),
    .busy        (busy),
    .frame_count (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  e0, e1, e2, e3;
    int          gap;
    logic [15:0] exp_arr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one element after 'gap' idle cycles and return just after its handshake edge.
  task automatic send_elem(input logic [3:0] d, input logic last, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_enable"}, sort_enable, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_array"}, sort_array, 16'h0000);
    check({tag, "_hi"}, sort_hi_ind, 4'd0);
    check({tag, "_lo"}, sort_lo_ind, 4'd0);
    check({tag, "_count"}, frame_count, 8'd0);
  endtask

  // Full 4-element frame; checks the issue cycle and the cycle after it.
  task automatic run_frame(input vec_t v);
    logic [3:0] el [4];
    el[0] = v.e0; el[1] = v.e1; el[2] = v.e2; el[3] = v.e3;
    for (int i = 0; i < 4; i++) begin
      send_elem(el[i], 1'b0, (i == 0) ? 0 : v.gap);
      if (i < 3) check({v.name, "_no_early_enable"}, sort_enable, 1'b0);
    end
    check({v.name, "_enable"}, sort_enable, 1'b1);
    check({v.name, "_ready_low"}, in_ready, 1'b0);
    check({v.name, "_busy"}, busy, 1'b1);
    check({v.name, "_array"}, sort_array, v.exp_arr);
    check({v.name, "_hi"}, sort_hi_ind, 4'd3);
    check({v.name, "_lo"}, sort_lo_ind, 4'd0);
    tick();
    check({v.name, "_enable_off"}, sort_enable, 1'b0);
    check({v.name, "_array_held"}, sort_array, v.exp_arr);
  endtask

  task automatic finish_frame(input string name, input logic [7:0] exp_count);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check({name, "_ready_back"}, in_ready, 1'b1);
    check({name, "_busy_clear"}, busy, 1'b0);
    check({name, "_count"}, frame_count, exp_count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();
  endtask

  vec_t vecs [4];
  int   bad;

  initial begin
    vecs[0] = '{"v0", 4'h3, 4'h1, 4'h2, 4'h0, 0, 16'h0213};
    vecs[1] = '{"v1", 4'hF, 4'h0, 4'hA, 4'h5, 1, 16'h5A0F};
    vecs[2] = '{"v2", 4'h7, 4'h7, 4'hC, 4'h1, 0, 16'h1C77};
    vecs[3] = '{"v3", 4'h9, 4'h8, 4'h6, 4'h4, 1, 16'h4689};

    reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; sort_done = 1'b0;
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;
    check("ready_still_low", in_ready, 1'b0);
    tick();
    check("ready_after_reset", in_ready, 1'b1);

    // Frame 0 plus 20 cycles of blocked input while waiting on the sorter
    run_frame(vecs[0]);
    in_valid = 1'b1;
    in_data  = 4'hA;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (in_ready !== 1'b0 || sort_array !== 16'h0213 || sort_enable !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    check("wait_blocked_cycles", bad, 0);
    finish_frame("v0", 8'd1);

    for (int k = 1; k < 4; k++) begin
      run_frame(vecs[k]);
      finish_frame(vecs[k].name, 8'(k + 1));
    end

    // sort_done during ISSUE must be ignored
    for (int i = 0; i < 4; i++) send_elem(4'(i + 2), 1'b0, 0);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check("issue_done_ready", in_ready, 1'b0);
    check("issue_done_busy", busy, 1'b1);
    check("issue_done_count", frame_count, 8'd4);
    check("issue_done_array", sort_array, 16'h5432);
    finish_frame("after_issue", 8'd5);

`ifdef SORT_LOADER_PARTIAL_EN
    send_elem(4'h5, 1'b0, 0);
    send_elem(4'h7, 1'b1, 0);
    check("part2_enable", sort_enable, 1'b1);
    check("part2_array", sort_array, 16'hFF75);
    check("part2_hi", sort_hi_ind, 4'd1);
    tick();
    finish_frame("part2", 8'd6);
    send_elem(4'h9, 1'b1, 0);
    check("part1_enable", sort_enable, 1'b1);
    check("part1_array", sort_array, 16'hFFF9);
    check("part1_hi", sort_hi_ind, 4'd0);
    tick();
    finish_frame("part1", 8'd7);
    send_elem(4'h1, 1'b0, 0);
    send_elem(4'h2, 1'b0, 0);
    send_elem(4'h3, 1'b0, 0);
    send_elem(4'h4, 1'b1, 0);
    check("last_full_array", sort_array, 16'h4321);
    check("last_full_hi", sort_hi_ind, 4'd3);
    tick();
    finish_frame("last_full", 8'd8);
`else
    send_elem(4'h1, 1'b0, 0);
    send_elem(4'h2, 1'b1, 0);
    check("last_ignored_enable", sort_enable, 1'b0);
    check("last_ignored_ready", in_ready, 1'b1);
    send_elem(4'h3, 1'b0, 0);
    send_elem(4'h4, 1'b0, 0);
    check("last_ignored_close", sort_enable, 1'b1);
    check("last_ignored_array", sort_array, 16'h4321);
    tick();
    finish_frame("last_ignored", 8'd6);
`endif

    // Reset while waiting on the sorter
    for (int i = 0; i < 4; i++) send_elem(4'hE, 1'b0, 0);
    tick();
    tick();
    do_reset();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (sort_enable !== 1'b0) bad++;
      tick();
    end
    check("wait_reset_no_enable", bad, 0);

    // Reset mid-fill after two elements; next frame must pack from slot 0
    send_elem(4'hB, 1'b0, 0);
    send_elem(4'hD, 1'b0, 0);
    do_reset();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (sort_enable !== 1'b0) bad++;
      tick();
    end
    check("fill_reset_no_enable", bad, 0);
    run_frame('{"post_reset", 4'h1, 4'h2, 4'h3, 4'h4, 0, 16'h4321});
    finish_frame("post_reset", 8'd1);

    // 256 frames with an immediate sort_done wrap the counter
    do_reset();
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 4; i++) send_elem(4'(f + i), 1'b0, 0);
      tick();
      sort_done = 1'b1;
      tick();
      sort_done = 1'b0;
      if (f == 254) check("count_255", frame_count, 8'd255);
    end
    check("count_wrap", frame_count, 8'd0);
    check("wrap_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
